// File: rtl/score_bcd_display_if.sv
// rtl/score_bcd_display_if.sv - request/result bundle between score counter and BCD display reader
interface score_bcd_display_if;
  logic        start;
  logic [7:0]  value;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  // The score side requests conversions and reads back results.
  modport master (
    output start,
    output value,
    input  busy,
    input  done,
    input  bcd
  );

  // The converter accepts requests and publishes results.
  modport slave (
    input  start,
    input  value,
    output busy,
    output done,
    output bcd
  );
endinterface

// File: rtl/score_bcd_display.sv
// rtl/score_bcd_display.sv - score to 3-digit BCD converter with 4-digit seven-segment scanner; option SCORE_BCD_DISPLAY_BLANK_LEADING_EN
module score_bcd_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic                 clock,
  input  logic                 reset,
  score_bcd_display_if.slave   bus,
  output logic [3:0]           an,
  output logic [6:0]           seg
);

  // A divide of 1 still needs a one-bit prescaler that simply sits at 0.
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  logic [7:0]   shreg;
  logic [11:0]  scratch;
  logic [3:0]   shcnt;
  logic         busy_q;
  logic         done_q;
  logic [11:0]  bcd_q;

  logic [PW-1:0] presc;
  logic [1:0]    idx;

  logic [6:0]   seg_ones;
  logic [6:0]   seg_tens;
  logic [6:0]   seg_hund;

  // Double-dabble correction: any nibble that would reach 10+ after doubling gets +3 first.
  function automatic logic [11:0] add3(input logic [11:0] s);
    logic [11:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (s[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low gfedcba patterns; anything outside 0..9 goes dark.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'b1000000;
      4'd1:    r = 7'b1111001;
      4'd2:    r = 7'b0100100;
      4'd3:    r = 7'b0110000;
      4'd4:    r = 7'b0011001;
      4'd5:    r = 7'b0010010;
      4'd6:    r = 7'b0000010;
      4'd7:    r = 7'b1111000;
      4'd8:    r = 7'b0000000;
      4'd9:    r = 7'b0010000;
      default: r = SEG_BLANK;
    endcase
    return r;
  endfunction

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

  // Per-digit segment patterns from the published result, with optional leading-zero blanking.
  always_comb begin
    seg_ones = seg_of(bcd_q[3:0]);
    seg_tens = seg_of(bcd_q[7:4]);
    seg_hund = seg_of(bcd_q[11:8]);
`ifdef SCORE_BCD_DISPLAY_BLANK_LEADING_EN
    if (bcd_q[11:8] == 4'd0) begin
      seg_hund = SEG_BLANK;
      if (bcd_q[7:4] == 4'd0) begin
        seg_tens = SEG_BLANK;
      end
    end
`endif
  end

  // Conversion FSM: capture on start, eight shift-add-3 steps, then publish to bcd for one done cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= 8'd0;
      scratch <= 12'd0;
      shcnt   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bcd_q   <= 12'd0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.value;
            scratch <= 12'd0;
            shcnt   <= 4'd0;
            busy_q  <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          // Top bit of the corrected scratch falls off; it is always 0 for an 8-bit input.
          scratch <= 12'({add3(scratch), shreg[7]});
          shreg   <= {shreg[6:0], 1'b0};
          shcnt   <= shcnt + 4'd1;
          if (shcnt == 4'd7) begin
            state <= DONE;
          end
        end
        DONE: begin
          bcd_q  <= scratch;
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Free-running display scan: prescaler paces the digit index; an/seg follow the pre-edge index and bcd.
  always_ff @(posedge clock) begin
    if (reset) begin
      presc <= '0;
      idx   <= 2'd0;
      an    <= 4'b1110;
      seg   <= 7'b1000000;
    end else begin
      if (presc == PRESC_LAST) begin
        presc <= '0;
        idx   <= idx + 2'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      case (idx)
        2'd0: begin
          an  <= 4'b1110;
          seg <= seg_ones;
        end
        2'd1: begin
          an  <= 4'b1101;
          seg <= seg_tens;
        end
        2'd2: begin
          an  <= 4'b1011;
          seg <= seg_hund;
        end
        default: begin
          an  <= 4'b0111;
          seg <= SEG_BLANK;
        end
      endcase
    end
  end

endmodule

// File: doc/score_bcd_display.md
Name: score_bcd_display

Overview:
- Reader side of the 8-bit score counter.
- Samples the 0..255 score on request and converts it to three BCD digits with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the digits onto a 4-digit common-anode seven-segment display.
- Sits between the game score counter and the board display pins.

Parameters:
SCAN_DIV, 100000, clock cycles each digit stays lit; legal range >= 1.

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset; sampled on the rising edge of clock
start  input  1  one-cycle request to capture value and convert it
value  input  8  binary score to convert
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd is updated
bcd  output  12  {hundreds, tens, ones}; each nibble 0..9
an  output  4  digit enables, active-low, one-hot-zero
seg  output  7  segments {g,f,e,d,c,b,a}, active-low

Behaviour:
- Reset values: busy=0, done=0, bcd=12'h000, an=4'b1110, seg=7'b1000000 ("0"). FSM=IDLE; prescaler, digit index and shift counter all 0.
- Reset takes priority over every other input. Reset mid-conversion aborts the conversion; bcd returns to 0 and no done pulse is produced.
- FSM states IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge N: latch value into an 8-bit shift register, clear the 12-bit scratch, clear the shift counter, go to SHIFT, busy=1 after edge N.
  - start=0: stay in IDLE.
- SHIFT:
  - At each edge, first add 3 to every scratch nibble that is >= 5. Then shift {scratch, shiftreg} left by 1 and increment the counter.
  - Runs exactly 8 times (edges N+1..N+8), then go to DONE.
- DONE:
  - At edge N+9: bcd <= scratch, done=1 for exactly that one cycle, busy=0, return to IDLE.
  - The next start is accepted at edge N+10 at the earliest.
- Latency from start sampled to bcd valid/done high: 9 cycles.
- start while busy=1 (SHIFT or DONE): ignored, not queued. value is don't-care outside the start cycle.
- bcd holds its last result until the next DONE or reset. Intermediate results are never visible on bcd.
- Scanner:
  - Runs continuously and independently of the FSM.
  - Prescaler counts 0..SCAN_DIV-1. On the edge where it equals SCAN_DIV-1, it wraps to 0 and the digit index advances 0→1→2→3→0.
  - an and seg are registered. At every edge they are driven from the index and bcd values held before that edge.
  - Index 0 = ones, an=1110. Index 1 = tens, an=1101. Index 2 = hundreds, an=1011. Index 3 = an=0111 with seg=7'b1111111 (blank; the score never exceeds 255).
- Segment patterns (gfedcba, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Nibble >9 (unreachable) = 1111111.
- When bcd updates mid-scan, the new digit values appear on seg one cycle later with no glitch on an.

Optional Feature:
- Macro: SCORE_BCD_DISPLAY_BLANK_LEADING_EN.
- Defined:
  - The hundreds digit is blanked (seg=1111111) when hundreds=0.
  - The tens digit is blanked when hundreds=0 and tens=0.
  - Ones is always shown. an sequencing is unchanged.
- Undefined: all three digits are always shown, including leading zeros.
- Conversion, busy/done and bcd are identical in both builds.

Test Plan:
- Reset, then start with value=8'd255 → busy=1 for 9 cycles; done pulses 1 cycle at the 9th edge after start; bcd=12'h255.
- value=8'd0 → bcd=12'h000; value=8'd99 → bcd=12'h099; value=8'd128 → bcd=12'h128. Sweep all 0..255 against a reference model.
- start pulsed again 3 cycles after the first (value=8'd7 then 8'd200) → second request ignored; bcd=12'h007; exactly one done.
- SCAN_DIV=4, bcd=12'h042 → an cycles 1110,1101,1011,0111 with each digit held 4 clocks; seg=0011001 ("4") while an=1101. With the macro defined, seg=1111111 while an=1011.
- Assert reset at SHIFT cycle 4 of converting 8'd255 → no done; bcd=12'h000; busy=0, an=1110, seg=1000000 after the reset edge. A subsequent start then converts correctly.
